// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel request/acknowledge arbiter serialising transactions onto one memory port.
// Build option MEM_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (channel 0 highest).
module mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH-1:0]    ch_write,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    input  logic [NUM_CH*2-1:0]  ch_width,
    input  logic [NUM_CH-1:0]    ch_extend,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic                 ch_err,
    output logic [DW-1:0]        ch_rdata,
    output logic                 bus_req,
    output logic [AW-1:0]        bus_addr,
    output logic                 bus_write,
    output logic [DW-1:0]        bus_wdata,
    output logic [1:0]           bus_width,
    output logic                 bus_extend,
    input  logic                 bus_ack,
    input  logic [DW-1:0]        bus_rdata
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t              state, state_n;
    logic [GW-1:0]       grant, grant_n;
    logic [GW-1:0]       winner;
    logic [WW-1:0]       wdog, wdog_n;
    logic                wdog_expired;

    logic [NUM_CH-1:0]   ch_ack_n;
    logic                ch_err_n;
    logic [DW-1:0]       ch_rdata_n;
    logic                bus_req_n;
    logic [AW-1:0]       bus_addr_n;
    logic                bus_write_n;
    logic [DW-1:0]       bus_wdata_n;
    logic [1:0]          bus_width_n;
    logic                bus_extend_n;

    // Watchdog fires on the last permitted BUSY cycle; TIMEOUT of zero disables it.
    assign wdog_expired = (TIMEOUT != 0) && (wdog == WW'(TIMEOUT - 1));

`ifdef MEM_ARB_RR_EN
    logic [GW-1:0]     rr_ptr, rr_ptr_n;
    logic [NUM_CH-1:0] req_rot;
    int                rr_off;
    int                rr_sum;

    // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        req_rot = NUM_CH'({ch_req, ch_req} >> rr_ptr);
        rr_off  = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rr_off = k;
            end
        end
        rr_sum = int'(rr_ptr) + rr_off;
        if (rr_sum >= NUM_CH) begin
            rr_sum = rr_sum - NUM_CH;
        end
        winner = GW'(rr_sum);
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_req[k]) begin
                winner = GW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        wdog_n       = wdog;
        ch_ack_n     = '0;
        ch_err_n     = 1'b0;
        ch_rdata_n   = ch_rdata;
        bus_req_n    = bus_req;
        bus_addr_n   = bus_addr;
        bus_write_n  = bus_write;
        bus_wdata_n  = bus_wdata;
        bus_width_n  = bus_width;
        bus_extend_n = bus_extend;
`ifdef MEM_ARB_RR_EN
        rr_ptr_n     = rr_ptr;
`endif

        case (state)
            IDLE: begin
                if (|ch_req) begin
                    grant_n      = winner;
                    bus_req_n    = 1'b1;
                    bus_addr_n   = ch_addr[int'(winner)*AW +: AW];
                    bus_write_n  = ch_write[winner];
                    bus_wdata_n  = ch_wdata[int'(winner)*DW +: DW];
                    bus_width_n  = ch_width[int'(winner)*2 +: 2];
                    bus_extend_n = ch_extend[winner];
                    wdog_n       = '0;
                    state_n      = BUSY;
                end
            end
            BUSY: begin
                // A real acknowledge takes precedence over a watchdog expiring in the same cycle.
                if (bus_ack) begin
                    ch_rdata_n      = bus_rdata;
                    bus_req_n       = 1'b0;
                    ch_ack_n[grant] = 1'b1;
                    ch_err_n        = 1'b0;
                    state_n         = RESP;
                end else if (wdog_expired) begin
                    ch_rdata_n      = '0;
                    bus_req_n       = 1'b0;
                    ch_ack_n[grant] = 1'b1;
                    ch_err_n        = 1'b1;
                    state_n         = RESP;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
`ifdef MEM_ARB_RR_EN
                rr_ptr_n = (grant == GW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            wdog       <= '0;
            ch_ack     <= '0;
            ch_err     <= 1'b0;
            ch_rdata   <= '0;
            bus_req    <= 1'b0;
            bus_addr   <= '0;
            bus_write  <= 1'b0;
            bus_wdata  <= '0;
            bus_width  <= '0;
            bus_extend <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ptr     <= '0;
`endif
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            wdog       <= wdog_n;
            ch_ack     <= ch_ack_n;
            ch_err     <= ch_err_n;
            ch_rdata   <= ch_rdata_n;
            bus_req    <= bus_req_n;
            bus_addr   <= bus_addr_n;
            bus_write  <= bus_write_n;
            bus_wdata  <= bus_wdata_n;
            bus_width  <= bus_width_n;
            bus_extend <= bus_extend_n;
`ifdef MEM_ARB_RR_EN
            rr_ptr     <= rr_ptr_n;
`endif
        end
    end

endmodule
